id_ex_pipeline_reg: RTL and testbench

- ID/EX pipeline register (PR2) of the 5-stage MIPS pipeline, with integrated load-use hazard detection.
- Captures decoded control, register-file read data, immediate and register numbers from ID.
- Presents them to EX and to the forwarding unit (RS, RT, RD, RegWrite, MemRead).
- Generates the stall that freezes PC and IF/ID, inserts bubbles, and handles branch flush and external memory hold.

---
 rtl/id_ex_pipeline_reg.sv | 156 +++++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and memory hold.
// Optional stall counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_pipeline_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUOP_W    = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic [ALUOP_W-1:0]    id_alu_op,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [DATA_W-1:0]     id_pc4,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dst,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic [DATA_W-1:0]     ex_rd1,
    output logic [DATA_W-1:0]     ex_rd2,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [DATA_W-1:0]     ex_pc4,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
`ifdef ID_EX_STALL_CNT_EN
    output logic [CNT_W-1:0]      stall_count,
`endif
    output logic                  hazard_stall,
    output logic                  pc_write_en,
    output logic                  if_id_write_en
);

    typedef struct packed {
        logic                  valid;
        logic                  regWrite;
        logic                  memRead;
        logic                  memWrite;
        logic                  memToReg;
        logic                  aluSrc;
        logic                  regDst;
        logic [ALUOP_W-1:0]    aluOp;
        logic [DATA_W-1:0]     rd1;
        logic [DATA_W-1:0]     rd2;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     pc4;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
    } exFields_t;

    exFields_t exQ;
    exFields_t idFields;
    logic      flushPending;
    logic      rtHit;

    // Gather the ID-stage payload; an all-zero struct is the bubble.
    always_comb begin
        idFields          = '0;
        idFields.valid    = 1'b1;
        idFields.regWrite = id_reg_write;
        idFields.memRead  = id_mem_read;
        idFields.memWrite = id_mem_write;
        idFields.memToReg = id_mem_to_reg;
        idFields.aluSrc   = id_alu_src;
        idFields.regDst   = id_reg_dst;
        idFields.aluOp    = id_alu_op;
        idFields.rd1      = id_rd1;
        idFields.rd2      = id_rd2;
        idFields.imm      = id_imm;
        idFields.pc4      = id_pc4;
        idFields.rs       = id_rs;
        idFields.rt       = id_rt;
        idFields.rd       = id_rd;
    end

    // Load in EX whose destination is read by ID; squashed ID instructions never stall.
    always_comb begin
        rtHit        = 1'b0;
        hazard_stall = 1'b0;
        rtHit        = (id_uses_rs && (id_rs == exQ.rt)) || (id_uses_rt && (id_rt == exQ.rt));
        hazard_stall = exQ.valid && exQ.memRead && (exQ.rt != '0) && rtHit
                       && !flush && !flushPending;
    end

    assign pc_write_en    = ~(hazard_stall | hold);
    assign if_id_write_en = ~(hazard_stall | hold);

    // Hold freezes EX but remembers a flush so it is applied once hold releases.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exQ          <= '0;
            flushPending <= 1'b0;
        end else if (hold) begin
            if (flush) begin
                flushPending <= 1'b1;
            end
        end else if (flush || flushPending) begin
            exQ          <= '0;
            flushPending <= 1'b0;
        end else if (hazard_stall) begin
            exQ <= '0;
        end else begin
            exQ <= idFields;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [CNT_W-1:0] stallCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (hazard_stall && !hold) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign stall_count = stallCnt;
`endif

    assign ex_valid      = exQ.valid;
    assign ex_reg_write  = exQ.regWrite;
    assign ex_mem_read   = exQ.memRead;
    assign ex_mem_write  = exQ.memWrite;
    assign ex_mem_to_reg = exQ.memToReg;
    assign ex_alu_src    = exQ.aluSrc;
    assign ex_reg_dst    = exQ.regDst;
    assign ex_alu_op     = exQ.aluOp;
    assign ex_rd1        = exQ.rd1;
    assign ex_rd2        = exQ.rd2;
    assign ex_imm        = exQ.imm;
    assign ex_pc4        = exQ.pc4;
    assign ex_rs         = exQ.rs;
    assign ex_rt         = exQ.rt;
    assign ex_rd         = exQ.rd;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: directed scenarios followed by randomized traffic.
// Checks stall_count as well when ID_EX_STALL_CNT_EN is defined.
module tb_id_ex_pipeline_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned OW = 2;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, hold, flush;
    logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
    logic [OW-1:0] id_alu_op;
    logic          id_uses_rs, id_uses_rt;
    logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc4;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
    logic [OW-1:0] ex_alu_op;
    logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic          hazard_stall, pc_write_en, if_id_write_en;
    logic [CW-1:0] stall_count;

    id_ex_pipeline_reg dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
        .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
`ifdef ID_EX_STALL_CNT_EN
        .stall_count(stall_count),
`endif
        .hazard_stall(hazard_stall), .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en)
    );

`ifndef ID_EX_STALL_CNT_EN
    assign stall_count = '0;
`endif

    typedef struct packed {
        logic valid, regWrite, memRead, memWrite, memToReg, aluSrc, regDst;
        logic [OW-1:0] aluOp;
        logic [DW-1:0] rd1, rd2, imm, pc4;
        logic [AW-1:0] rs, rt, rd;
    } ex_t;

    typedef struct packed {
        logic rstN, hold, flush;
        logic regWrite, memRead, memWrite, memToReg, aluSrc, regDst;
        logic [OW-1:0] aluOp;
        logic usesRs, usesRt;
        logic [DW-1:0] rd1, rd2, imm, pc4;
        logic [AW-1:0] rs, rt, rd;
    } stim_t;

    typedef struct packed {
        ex_t           ex;
        logic          hz;
        logic          we;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sbq[$];
    ex_t           mEx;
    logic          mPend;
    logic [CW-1:0] mCnt;
    bit            mKnown;
    int            checks;
    int            errors;
    ex_t           dutEx;

    assign dutEx = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
                    ex_reg_dst, ex_alu_op, ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd};

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s      = '0;
        s.rstN = 1'b1;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s          = '0;
        s.rstN     = ($urandom_range(99) != 0);
        s.hold     = ($urandom_range(7) == 0);
        s.flush    = ($urandom_range(9) == 0);
        s.regWrite = 1'($urandom);
        s.memRead  = 1'($urandom);
        s.memWrite = 1'($urandom);
        s.memToReg = 1'($urandom);
        s.aluSrc   = 1'($urandom);
        s.regDst   = 1'($urandom);
        s.aluOp    = OW'($urandom);
        s.usesRs   = ($urandom_range(3) != 0);
        s.usesRt   = ($urandom_range(3) != 0);
        s.rd1      = $urandom;
        s.rd2      = $urandom;
        s.imm      = $urandom;
        s.pc4      = $urandom;
        s.rs       = AW'($urandom_range(3));
        s.rt       = AW'($urandom_range(3));
        s.rd       = AW'($urandom);
        return s;
    endfunction

    // Drive one cycle, record what the outputs must show this cycle, then advance the model.
    task automatic step(input stim_t s);
        logic hz;
        exp_t e;
        ex_t  ld;
        @(posedge clk);
        #2;
        rst_n = s.rstN; hold = s.hold; flush = s.flush;
        id_reg_write = s.regWrite; id_mem_read = s.memRead; id_mem_write = s.memWrite;
        id_mem_to_reg = s.memToReg; id_alu_src = s.aluSrc; id_reg_dst = s.regDst;
        id_alu_op = s.aluOp; id_uses_rs = s.usesRs; id_uses_rt = s.usesRt;
        id_rd1 = s.rd1; id_rd2 = s.rd2; id_imm = s.imm; id_pc4 = s.pc4;
        id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;

        hz = mEx.valid && mEx.memRead && (mEx.rt != 0)
             && ((s.usesRs && s.rs == mEx.rt) || (s.usesRt && s.rt == mEx.rt))
             && !s.flush && !mPend;
        if (mKnown) begin
            e.ex  = mEx;
            e.hz  = hz;
            e.we  = !(hz || s.hold);
            e.cnt = mCnt;
            sbq.push_back(e);
        end

        ld = {1'b1, s.regWrite, s.memRead, s.memWrite, s.memToReg, s.aluSrc, s.regDst, s.aluOp,
              s.rd1, s.rd2, s.imm, s.pc4, s.rs, s.rt, s.rd};
        if (!s.rstN) begin
            mEx = '0; mPend = 1'b0; mCnt = '0; mKnown = 1'b1;
        end else begin
            if (hz && !s.hold) mCnt = mCnt + CW'(1);
            if (s.hold)                 mPend = mPend | s.flush;
            else if (s.flush || mPend) begin mEx = '0; mPend = 1'b0; end
            else if (hz)                mEx = '0;
            else                        mEx = ld;
        end
    endtask

    task automatic peek();
        #4;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("ex_regs", 160'(dutEx), 160'(e.ex));
            chk("hazard_stall", 160'(hazard_stall), 160'(e.hz));
            chk("pc_write_en", 160'(pc_write_en), 160'(e.we));
            chk("if_id_write_en", 160'(if_id_write_en), 160'(e.we));
`ifdef ID_EX_STALL_CNT_EN
            chk("stall_count", 160'(stall_count), 160'(e.cnt));
`endif
        end
    end

    initial begin
        stim_t s, u, l, a, h, hf, b, f, r, n;
        checks = 0; errors = 0;
        mEx = '0; mPend = 1'b0; mCnt = '0; mKnown = 1'b0;
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        id_alu_src = 0; id_reg_dst = 0; id_alu_op = '0; id_uses_rs = 0; id_uses_rt = 0;
        id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_pc4 = '0; id_rs = '0; id_rt = '0; id_rd = '0;

        r = idle(); r.rstN = 1'b0;
        step(r); step(r);
        step(idle()); peek();
        chk("reset_state", 160'(dutEx), 160'(0));

        // Plain load
        s = idle(); s.regWrite = 1'b1; s.rd1 = 32'h1234; s.rt = 5'd8;
        step(s); step(idle()); peek();
        chk("plain_valid", 160'(ex_valid), 160'(1));
        chk("plain_rd1", 160'(ex_rd1), 160'(32'h1234));
        chk("plain_rt", 160'(ex_rt), 160'(8));
        chk("plain_no_stall", 160'(hazard_stall), 160'(0));

        // Load-use stall
        l = idle(); l.memRead = 1'b1; l.regWrite = 1'b1; l.rt = 5'd9;
        u = idle(); u.rs = 5'd9; u.usesRs = 1'b1;
        step(l); step(u); peek();
        chk("lu_stall", 160'(hazard_stall), 160'(1));
        chk("lu_pc_we", 160'(pc_write_en), 160'(0));
        step(u); peek();
        chk("lu_bubble_valid", 160'(ex_valid), 160'(0));
        chk("lu_bubble_memrd", 160'(ex_mem_read), 160'(0));
        chk("lu_released", 160'(hazard_stall), 160'(0));
        step(u); peek();
        chk("lu_loaded", 160'({ex_valid, ex_rs}), 160'({1'b1, 5'd9}));

        // Register zero never stalls
        s = idle(); s.memRead = 1'b1; s.rt = 5'd0;
        step(s);
        s = idle(); s.usesRs = 1'b1; s.rs = 5'd0;
        step(s); peek();
        chk("zero_no_stall", 160'(hazard_stall), 160'(0));
        step(idle()); peek();
        chk("zero_loaded", 160'(ex_valid), 160'(1));

        // Flush arriving during a 3-cycle hold
        a = idle(); a.regWrite = 1'b1; a.rd1 = 32'hAAAA_0001;
        h = idle(); h.hold = 1'b1;
        hf = h; hf.flush = 1'b1;
        b = idle(); b.rd1 = 32'hBBBB_0002;
        step(a); step(h); peek();
        chk("hold_start", 160'({ex_valid, ex_rd1}), 160'({1'b1, 32'hAAAA_0001}));
        step(hf); step(h); step(b); peek();
        chk("hold_kept", 160'({ex_valid, ex_rd1}), 160'({1'b1, 32'hAAAA_0001}));
        step(b); peek();
        chk("hold_flush_bubble", 160'(ex_valid), 160'(0));
        step(b); peek();
        chk("hold_after_flush", 160'({ex_valid, ex_rd1}), 160'({1'b1, 32'hBBBB_0002}));

        // Flush masks a load-use stall
        f = u; f.flush = 1'b1;
        step(l); step(f); peek();
        chk("flush_mask_stall", 160'(hazard_stall), 160'(0));
        chk("flush_mask_pc_we", 160'(pc_write_en), 160'(1));
        step(idle()); peek();
        chk("flush_mask_bubble", 160'(ex_valid), 160'(0));

        // Reset clears pending flush and EX contents
        n = idle(); n.rd1 = 32'h5;
        step(a); step(hf); step(r); step(n); peek();
        chk("rst_mid_clear", 160'({ex_valid, ex_rd1}), 160'(0));
        step(n); peek();
        chk("rst_no_pending", 160'({ex_valid, ex_rd1}), 160'({1'b1, 32'h5}));

`ifdef ID_EX_STALL_CNT_EN
        step(r);
        step(l); step(u); step(u); step(l); step(u); step(u); step(idle()); peek();
        chk("stall_count_two", 160'(stall_count), 160'(2));
`endif

        for (int i = 0; i < 3000; i++) begin
            step(randStim());
        end

        step(idle()); step(idle());
        repeat (3) @(negedge clk);
        #1;
        chk("sb_drain", 160'(sbq.size()), 160'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
